// File: rtl/ir_fetch_pkg.sv
// Shared types for the instruction fetch / immediate generation block.
package ir_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      IMM_SE    = 2'd0,
      IMM_ZE    = 2'd1,
      IMM_SE_SH = 2'd2,
      IMM_ZE_SH = 2'd3
   } imm_mode_e;

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction: SE/ZE/shifted views of the current IR and the
// mode-selected immediate for the word about to be loaded.
module imm_gen
   import ir_fetch_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 10,
   parameter int IMM_W     = 8,
   parameter int IMM_LSB   = 4,
   parameter int SHAMT_W   = 4,
   parameter int SHAMT_LSB = 2
) (
   input  logic [DATA_W-1:0] ir_i,
   input  logic [DATA_W-1:0] nxt_i,
   input  logic [1:0]        mode_i,
   output logic [DATA_W-1:0] se_o,
   output logic [DATA_W-1:0] ze_o,
   output logic [DATA_W-1:0] sh_o,
   output logic [DATA_W-1:0] sel_o
);

   function automatic logic [DATA_W-1:0] ext(
      input logic [DATA_W-1:0] w,
      input logic              sgn
   );
      logic [IMM_W-1:0] f;
      f = w[IMM_LSB +: IMM_W];
      return {{(DATA_W-IMM_W){sgn & f[IMM_W-1]}}, f};
   endfunction

   // Shift amount always comes from the word itself, not the value shifted.
   function automatic logic [DATA_W-1:0] shl(
      input logic [DATA_W-1:0] v,
      input logic [DATA_W-1:0] w
   );
      logic [SHAMT_W-1:0] s;
      s = w[SHAMT_LSB +: SHAMT_W];
      if (32'(s) >= DATA_W) begin
         return '0;
      end
      return v << s;
   endfunction

   assign se_o = ext(ir_i, 1'b1);
   assign ze_o = ext(ir_i, 1'b0);
   assign sh_o = shl(se_o, ir_i);

   always_comb begin
      sel_o = '0;
      unique case (imm_mode_e'(mode_i))
         IMM_SE:    sel_o = ext(nxt_i, 1'b1);
         IMM_ZE:    sel_o = ext(nxt_i, 1'b0);
         IMM_SE_SH: sel_o = shl(ext(nxt_i, 1'b1), nxt_i);
         IMM_ZE_SH: sel_o = shl(ext(nxt_i, 1'b0), nxt_i);
         default:   sel_o = '0;
      endcase
   end

endmodule

// File: rtl/ir_fetch_imm.sv
// Instruction RAM with handshaked fetch into an IR, plus registered
// and combinational immediates derived from the fetched word.
module ir_fetch_imm
   import ir_fetch_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 10,
   parameter int IMM_W     = 8,
   parameter int IMM_LSB   = 4,
   parameter int SHAMT_W   = 4,
   parameter int SHAMT_LSB = 2
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] dina,
   input  logic              fetch_valid,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   input  logic [1:0]        imm_mode,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] SEout,
   output logic [DATA_W-1:0] ZEout,
   output logic [DATA_W-1:0] ShifterOut,
   output logic [DATA_W-1:0] imm_out
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] ir_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] imm_d;
   logic [1:0]        mode_q;
   state_e            state_q;
   state_e            state_d;
   logic              accept;
   logic              load;

   // A host write always wins the cycle, so read and write never collide.
   assign fetch_ready = !wea &&
      (state_q == IDLE || (state_q == HOLD && ir_ready));
   assign accept = fetch_valid && fetch_ready;
   assign load   = state_q == READ;

   always_ff @(posedge CLK) begin
      if (wea) begin
         mem_q[addra] <= dina;
      end
      if (accept) begin
         rdata_q <= mem_q[fetch_addr];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = READ;
         end
         READ: state_d = HOLD;
         HOLD: begin
            if (ir_ready) state_d = accept ? READ : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ir_q    <= '0;
         imm_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            mode_q <= imm_mode;
         end
         if (load) begin
            ir_q  <= rdata_q;
            imm_q <= imm_d;
         end
      end
   end

   imm_gen #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .IMM_W     (IMM_W),
      .IMM_LSB   (IMM_LSB),
      .SHAMT_W   (SHAMT_W),
      .SHAMT_LSB (SHAMT_LSB)
   ) u_imm_gen (
      .ir_i   (ir_q),
      .nxt_i  (rdata_q),
      .mode_i (mode_q),
      .se_o   (SEout),
      .ze_o   (ZEout),
      .sh_o   (ShifterOut),
      .sel_o  (imm_d)
   );

   assign ir       = ir_q;
   assign imm_out  = imm_q;
   assign ir_valid = state_q == HOLD;

endmodule

// File: tb/tb_ir_fetch_imm.sv
// Randomised and directed bench for ir_fetch_imm against a pipeline model.
module tb_ir_fetch_imm;

   localparam int DW = 16;
   localparam int AW = 10;

   logic          CLK = 1'b0;
   logic          reset;
   logic          wea;
   logic [AW-1:0] addra;
   logic [DW-1:0] dina;
   logic          fetch_valid;
   logic [AW-1:0] fetch_addr;
   logic          fetch_ready;
   logic [1:0]    imm_mode;
   logic          ir_valid;
   logic          ir_ready;
   logic [DW-1:0] ir, SEout, ZEout, ShifterOut, imm_out;

   logic          b_wea, b_fv, b_fr, b_irv, b_irr;
   logic [3:0]    b_addra, b_fa;
   logic [1:0]    b_mode;
   logic [31:0]   b_dina, b_ir, b_se, b_ze, b_sh, b_imm;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] m_mem [1<<AW];
   bit            m_pend;
   logic [DW-1:0] m_word;
   logic [1:0]    m_mode;
   bit            m_valid;
   logic [DW-1:0] m_ir;
   logic [DW-1:0] m_imm;

   always #5 CLK = ~CLK;

   ir_fetch_imm dut (
      .CLK(CLK), .reset(reset), .wea(wea), .addra(addra),
      .dina(dina), .fetch_valid(fetch_valid),
      .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .imm_mode(imm_mode), .ir_valid(ir_valid),
      .ir_ready(ir_ready), .ir(ir), .SEout(SEout),
      .ZEout(ZEout), .ShifterOut(ShifterOut), .imm_out(imm_out)
   );

   ir_fetch_imm #(
      .DATA_W(32), .ADDR_W(4), .IMM_W(12), .IMM_LSB(0)
   ) dut32 (
      .CLK(CLK), .reset(reset), .wea(b_wea), .addra(b_addra),
      .dina(b_dina), .fetch_valid(b_fv),
      .fetch_addr(b_fa), .fetch_ready(b_fr),
      .imm_mode(b_mode), .ir_valid(b_irv),
      .ir_ready(b_irr), .ir(b_ir), .SEout(b_se),
      .ZEout(b_ze), .ShifterOut(b_sh), .imm_out(b_imm)
   );

   function automatic logic [15:0] f_se(logic [15:0] w);
      int f;
      f = (int'(w) >> 4) & 255;
      if (f >= 128) f = f - 256;
      return 16'(f);
   endfunction

   function automatic logic [15:0] f_ze(logic [15:0] w);
      return 16'((int'(w) >> 4) & 255);
   endfunction

   function automatic int f_amt(logic [15:0] w);
      return (int'(w) >> 2) & 15;
   endfunction

   function automatic logic [15:0] f_shl(logic [15:0] v, int s);
      if (s >= 16) return 16'h0;
      return 16'(int'(v) << s);
   endfunction

   function automatic logic [15:0] f_imm(logic [15:0] w, logic [1:0] md);
      case (md)
         2'd0:    return f_se(w);
         2'd1:    return f_ze(w);
         2'd2:    return f_shl(f_se(w), f_amt(w));
         default: return f_shl(f_ze(w), f_amt(w));
      endcase
   endfunction

   // Ready when nothing is being read and the output slot is free or draining.
   function automatic bit m_ready();
      return !wea && !m_pend && (!m_valid || ir_ready);
   endfunction

   task automatic model_step();
      bit acc;
      acc = fetch_valid && m_ready();
      if (m_pend) begin
         m_ir    = m_word;
         m_imm   = f_imm(m_word, m_mode);
         m_valid = 1'b1;
         m_pend  = 1'b0;
      end else if (m_valid && ir_ready) begin
         m_valid = 1'b0;
      end
      if (acc) begin
         m_pend = 1'b1;
         m_word = m_mem[fetch_addr];
         m_mode = imm_mode;
      end
      if (wea) m_mem[addra] = dina;
   endtask

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("ir_valid", 32'(ir_valid), 32'(m_valid));
         chk("fetch_ready", 32'(fetch_ready), 32'(m_ready()));
         chk("ir", 32'(ir), 32'(m_ir));
         chk("imm_out", 32'(imm_out), 32'(m_imm));
         chk("SEout", 32'(SEout), 32'(f_se(m_ir)));
         chk("ZEout", 32'(ZEout), 32'(f_ze(m_ir)));
         chk("ShifterOut", 32'(ShifterOut),
             32'(f_shl(f_se(m_ir), f_amt(m_ir))));
      end
   end

   task automatic drive(bit we, int a, logic [15:0] d, bit fv,
                        int fa, int md, bit rr);
      wea         = we;
      addra       = AW'(a);
      dina        = d;
      fetch_valid = fv;
      fetch_addr  = AW'(fa);
      imm_mode    = 2'(md);
      ir_ready    = rr;
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      #2;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      chk("rst_async_ir", 32'(ir), 32'h0);
      chk("rst_async_valid", 32'(ir_valid), 32'h0);
      chk("rst_async_imm", 32'(imm_out), 32'h0);
      m_pend  = 1'b0;
      m_valid = 1'b0;
      m_ir    = '0;
      m_imm   = '0;
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 16'h0, 0, 0, 0, 0);
      b_wea = 0; b_addra = 0; b_dina = 0;
      b_fv = 0; b_fa = 0; b_mode = 0; b_irr = 0;
      m_pend = 0; m_valid = 0; m_ir = '0; m_imm = '0;
      m_word = '0; m_mode = '0;
      repeat (2) @(posedge CLK);
      #2;
      chk("rst_ir", 32'(ir), 32'h0);
      chk("rst_valid", 32'(ir_valid), 32'h0);
      chk("rst_imm", 32'(imm_out), 32'h0);
      chk("rst_se", 32'(SEout), 32'h0);
      chk("rst_sh", 32'(ShifterOut), 32'h0);
      reset = 1'b0;
      chk_en = 1'b1;

      drive(1, 5, 16'h0A3C, 0, 0, 0, 0); tick();
      drive(1, 7, 16'h0124, 0, 0, 0, 0); tick();
      drive(0, 0, 16'h0, 1, 5, 2, 0); tick();
      chk("m2_lat_read", 32'(ir_valid), 32'h0);
      drive(0, 0, 16'h0, 0, 0, 0, 0); tick();
      chk("m2_valid", 32'(ir_valid), 32'h1);
      chk("m2_ir", 32'(ir), 32'h0A3C);
      chk("m2_se", 32'(SEout), 32'hFFA3);
      chk("m2_ze", 32'(ZEout), 32'h00A3);
      chk("m2_sh", 32'(ShifterOut), 32'h8000);
      chk("m2_imm", 32'(imm_out), 32'h8000);

      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 16'h0, 1, 7, 3, 0);
         #1;
         chk("hold_ready", 32'(fetch_ready), 32'h0);
         tick();
         chk("hold_ir", 32'(ir), 32'h0A3C);
         chk("hold_imm", 32'(imm_out), 32'h8000);
         chk("hold_valid", 32'(ir_valid), 32'h1);
      end
      drive(0, 0, 16'h0, 1, 7, 3, 1);
      #1;
      chk("b2b_ready", 32'(fetch_ready), 32'h1);
      tick();
      chk("b2b_read_valid", 32'(ir_valid), 32'h0);
      chk("b2b_retain_ir", 32'(ir), 32'h0A3C);
      drive(0, 0, 16'h0, 0, 0, 0, 1); tick();
      chk("m3_valid", 32'(ir_valid), 32'h1);
      chk("m3_ir", 32'(ir), 32'h0124);
      chk("m3_se", 32'(SEout), 32'h0012);
      chk("m3_ze", 32'(ZEout), 32'h0012);
      chk("m3_sh", 32'(ShifterOut), 32'h2400);
      chk("m3_imm", 32'(imm_out), 32'h2400);
      tick();
      chk("drain_valid", 32'(ir_valid), 32'h0);
      chk("drain_retain", 32'(ir), 32'h0124);

      drive(1, 9, 16'hC3F0, 1, 9, 0, 0);
      #1;
      chk("wr_blocks_ready", 32'(fetch_ready), 32'h0);
      tick();
      drive(0, 0, 16'h0, 1, 9, 0, 0); tick();
      chk("wr_no_accept", 32'(ir_valid), 32'h0);
      drive(0, 0, 16'h0, 0, 0, 0, 0); tick();
      chk("wr_new_valid", 32'(ir_valid), 32'h1);
      chk("wr_new_ir", 32'(ir), 32'hC3F0);
      chk("wr_new_imm", 32'(imm_out), 32'h003F);
      drive(0, 0, 16'h0, 0, 0, 0, 1); tick();

      drive(0, 0, 16'h0, 1, 7, 1, 0); tick();
      pulse_reset();
      drive(0, 0, 16'h0, 0, 0, 0, 0); tick();
      tick();
      chk("abort_valid", 32'(ir_valid), 32'h0);
      drive(0, 0, 16'h0, 1, 5, 0, 0); tick();
      drive(0, 0, 16'h0, 0, 0, 0, 0); tick();
      chk("ram_kept_ir", 32'(ir), 32'h0A3C);
      chk("ram_kept_imm", 32'(imm_out), 32'hFFA3);
      drive(0, 0, 16'h0, 0, 0, 0, 1); tick();

      b_wea = 1; b_addra = 4'd3; b_dina = 32'h0000_0800; tick();
      b_wea = 0; b_fv = 1; b_fa = 4'd3; b_mode = 2'd1; tick();
      b_fv = 0; tick();
      chk("w32_valid", 32'(b_irv), 32'h1);
      chk("w32_ir", b_ir, 32'h0000_0800);
      chk("w32_se", b_se, 32'hFFFF_F800);
      chk("w32_ze", b_ze, 32'h0000_0800);
      chk("w32_imm", b_imm, 32'h0000_0800);

      for (int i = 0; i < 16; i++) begin
         drive(1, i, 16'($urandom), 0, 0, 0, 0);
         tick();
      end
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) == 0) pulse_reset();
         drive($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
               16'($urandom), $urandom_range(0, 3) != 0,
               int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1);
         tick();
      end

      drive(0, 0, 16'h0, 0, 0, 0, 1);
      tick();
      tick();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ir_fetch_imm.md
IR_FETCH_IMM -- requirements
Module: ir_fetch_imm

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction/data word width.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning memory address width; depth is 2**ADDR_W.
REQ-003 SHALL have parameter IMM_W, default 8, meaning immediate field width.
REQ-004 SHALL have parameter IMM_LSB, default 4, meaning immediate field LSB position in IR.
REQ-005 SHALL have parameters SHAMT_W, default 4, and SHAMT_LSB, default 2, meaning shift-amount field width and LSB in IR.
REQ-006 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous and active-high.
REQ-008 SHALL have ports wea (input, 1), addra (input, ADDR_W) and dina (input, DATA_W), meaning host memory write.
REQ-009 SHALL have ports fetch_valid (input, 1), fetch_addr (input, ADDR_W) and fetch_ready (output, 1), meaning fetch request handshake.
REQ-010 SHALL have ports imm_mode (input, 2), meaning immediate select, sampled on fetch accept.
REQ-011 SHALL have ports ir_valid (output, 1), ir_ready (input, 1) and ir (output, DATA_W), meaning instruction-out handshake.
REQ-012 SHALL have outputs SEout, ZEout, ShifterOut and imm_out, each DATA_W, meaning immediates derived from ir.

Function
REQ-013 SHALL contain a synchronous-read RAM whose read-data register loads only on an accepted fetch.
REQ-014 SHALL write dina to mem[addra] on a rising edge when wea=1.
REQ-015 SHALL accept a fetch on an edge where fetch_valid and fetch_ready are both 1.
REQ-016 SHALL implement FSM states IDLE, READ and HOLD.
REQ-017 SHALL transition IDLE->READ on accept; READ->HOLD unconditionally, loading ir with read data; HOLD->READ on ir_ready with accept; HOLD->IDLE on ir_ready without accept.
REQ-018 SHALL drive fetch_ready = !wea && (state==IDLE || (state==HOLD && ir_ready)), so a write always blocks fetch accept.
REQ-019 SHALL assert ir_valid only in HOLD; latency from accept edge to ir_valid=1 is 2 cycles; back-to-back throughput is one instruction per 2 cycles.
REQ-020 SHALL keep ir, ir_valid and imm_out stable in HOLD while ir_ready=0.
REQ-021 SHALL retain ir after consumption until the next load.
REQ-022 SHALL compute SEout as ir[IMM_LSB+IMM_W-1:IMM_LSB] sign-extended to DATA_W, and ZEout as the same field zero-extended.
REQ-023 SHALL compute ShifterOut = SEout << ir[SHAMT_LSB+SHAMT_W-1:SHAMT_LSB] (logical), yielding 0 when shamt >= DATA_W.
REQ-024 SHALL register imm_out at the ir load edge: mode 0=SE, 1=ZE, 2=SE shifted, 3=ZE shifted, using the mode captured at accept.
REQ-025 SHALL give a write to the address of an in-flight fetch no effect on the fetched data, since the read completed at the accept edge.

Reset
REQ-026 SHALL, while reset=1, force state=IDLE, ir=0, ir_valid=0, imm_out=0 and the captured mode=0; SEout, ZEout and ShifterOut are then 0.
REQ-027 SHALL abort an in-flight fetch on reset assertion mid-READ/HOLD, never delivering it.
REQ-028 SHALL leave RAM contents unaffected by reset.

Structure
REQ-029 SHALL place the FSM state enum and imm_mode encodings in shared package ir_fetch_pkg.
REQ-030 SHALL place the combinational SE/ZE/shift/select logic in one sub-module imm_gen, parametrised identically.

Verification
REQ-031 SHALL verify: write mem[5]=16'h0A3C, fetch 5 with mode 2 -> ir_valid 2 cycles later, ir=16'h0A3C, SEout=16'hFFA3, ZEout=16'h00A3, ShifterOut=16'h8000, imm_out=16'h8000.
REQ-032 SHALL verify: mem[7]=16'h0124, fetch 7 with mode 3 -> SEout=ZEout=16'h0012, ShifterOut=16'h2400, imm_out=16'h2400.
REQ-033 SHALL verify: hold ir_ready=0 for 5 cycles in HOLD -> ir and imm_out unchanged, fetch_ready=0; then ir_ready=1 with fetch_valid=1 -> state READ, next word delivered 2 cycles later.
REQ-034 SHALL verify: wea=1 with fetch_valid=1 in IDLE -> fetch_ready=0, no accept; write lands; fetch accepted the next cycle returns the new word.
REQ-035 SHALL verify: reset pulsed in READ -> ir=0, ir_valid=0 immediately (asynchronous), RAM still returns previously written words afterwards.
REQ-036 SHALL verify: DATA_W=32, IMM_W=12, IMM_LSB=0 instance with ir=32'h00000800 -> SEout=32'hFFFFF800, ZEout=32'h00000800.
